lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store sequencer between the MEM stage and a variable-latency data-memory port. Takes the MemRead/MemWrite decode and funct3 of the instruction in MEM. Runs a req/gnt/rvalid handshake to memory and stalls the pipeline until the access completes. Performs byte-lane steering for stores and sign/zero extension for loads, and flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 16: max cycles waiting in REQ+WAIT before abort (≥2).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load in MEM stage.
- MemWrite  in  1  store in MEM stage; wins if both high.
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Addr  in  32  byte address from ALU.
- WrData  in  32  store data (rs2).
- Stall  out  1  freeze PC and IF/ID/EX/MEM registers.
- RdData  out  32  extended load data, valid in DONE cycle, else 0.
- MisalignErr  out  1  one-cycle pulse, misaligned access rejected.
- BusErr  out  1  one-cycle pulse, timeout abort.
- mem_req  out  1  request to memory.
- mem_we  out  1  1 = write.
- mem_addr  out  32  Addr with [1:0] forced to 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables (writes only; 0 on reads).
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: if (MemRead|MemWrite) and aligned, capture Addr/Funct3/WrData/we, go REQ; Stall=1 combinationally this cycle. If misaligned (W: Addr[1:0]≠0; H/HU: Addr[0]≠0): MisalignErr=1, Stall=0, stay IDLE, no mem_req.
- REQ: mem_req=1, mem_* from captured regs. gnt & we → DONE; gnt & !we → WAIT. rvalid ignored in REQ.
- WAIT: mem_req=0; rvalid → latch extended data, go DONE.
- DONE: Stall=0, RdData valid (reads), MemRead/MemWrite ignored (same instruction still in MEM); → IDLE.
- Timeout: counter cleared on entering REQ, increments in REQ/WAIT; when it reaches TIMEOUT → DONE with BusErr=1, RdData=0.
- Store steering: B: be=0001<<Addr[1:0], wdata={4{WrData[7:0]}}; H: be=0011<<Addr[1:0], wdata={2{WrData[15:0]}}; W: be=1111.
- Load extract: byte at rdata[8*Addr[1:0]+:8], half at rdata[16*Addr[1]+:16]; B/H sign-extend, BU/HU zero-extend, W as is.
- Undefined Funct3 (011,110,111) treated as W.
- mem_rvalid in IDLE/DONE ignored (stale response after reset).

## Timing
- Reset: state IDLE, counter 0, all outputs 0.
- Store, gnt first REQ cycle: Stall high 2 cycles (IDLE-detect, REQ), DONE in third.
- Load, gnt first REQ cycle, rvalid next: Stall high 3 cycles, RdData in 4th.
- Each cycle of gnt/rvalid delay adds one stall cycle.
- Reset mid-access: IDLE next edge, mem_req low from that cycle, captured data discarded.
- Stall, mem_req, error pulses are functions of registered state plus IDLE-detect logic only; no input→mem_req combinational path.

## Structure
- lsu_pkg: state enum, Funct3 constants (F3_B/H/W/BU/HU), byte-enable helpers.
- Sub-module lsu_align: combinational store lane steering and load extraction; instantiated once, driven from captured Addr/Funct3.

## Test plan
- SW Addr 0x104, WrData 0xDEADBEEF, gnt immediate → mem_addr 0x104, mem_be 1111, mem_wdata 0xDEADBEEF, Stall 2 cycles.
- SB Addr 0x103, WrData 0x000000A5 → mem_be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x100.
- LB Addr 0x102, rdata 0x12F45678, gnt delayed 3 cycles → RdData 0xFFFFFFF4, Stall 6 cycles; repeat LBU → 0x000000F4; LHU Addr 0x102 → 0x000012F4.
- LW Addr 0x102 → MisalignErr pulse, mem_req never high, Stall 0.
- LH Addr 0x100, gnt never → after 16 REQ cycles BusErr pulse, RdData 0, Stall drops, next access accepted.
- Reset in WAIT, rvalid one cycle later → IDLE, outputs 0, RdData stays 0, no DONE.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
//   lsu_state_t      - sequencer state encoding
//   F3_*             - Funct3 access size/sign codes
//   is_byte/is_half  - classify a Funct3 (undefined codes fall to word)
//   be_of            - store byte-enable pattern for a size and address offset
//   misaligned       - true when the access straddles its natural boundary
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] lo);
        if (is_byte(f3))
            return 4'b0001 << lo;
        else if (is_half(f3))
            return 4'b0011 << lo;
        else
            return 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        if (is_byte(f3))
            return 1'b0;
        else if (is_half(f3))
            return lo[0];
        else
            return lo != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for stores and extraction /
// extension for loads.
//   addr_lo  in   2  byte offset of the access
//   funct3   in   3  access size/sign
//   wrdata   in  32  store data
//   rdata    in  32  word returned by memory
//   be       out  4  store byte enables
//   wdata    out 32  lane-replicated store data
//   ldata    out 32  extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wrdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign be       = be_of(funct3, addr_lo);

    // Replicating the narrow datum across all lanes lets memory pick it up
    // from whichever lane the byte enables select.
    always_comb begin
        wdata = wrdata;
        if (is_byte(funct3))
            wdata = {4{wrdata[7:0]}};
        else if (is_half(funct3))
            wdata = {2{wrdata[15:0]}};
    end

    always_comb begin
        ldata = rdata;
        case (funct3)
            F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ldata = {24'h0, byte_sel};
            F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ldata = {16'h0, half_sel};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the MEM stage and a variable-latency
// data-memory port (req/gnt/rvalid). Stalls the pipeline until the access
// completes, rejects misaligned accesses and aborts on timeout.
//   clk, reset                     clock, synchronous active-high reset
//   MemRead, MemWrite, Funct3      decode of the instruction in MEM
//   Addr, WrData                   byte address and store data
//   Stall                          freeze the pipeline front end
//   RdData                         extended load data, valid in DONE only
//   MisalignErr, BusErr            one-cycle error pulses
//   mem_req/we/addr/wdata/be       request side of the memory port
//   mem_gnt/rvalid/rdata           response side of the memory port
//
// state  | meaning
// IDLE   | no access in flight; detect, check alignment, capture request
// REQ    | mem_req high, waiting for mem_gnt
// WAIT   | load granted, waiting for mem_rvalid
// DONE   | access finished; release stall, present RdData / BusErr
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic        Stall,
    output logic [31:0] RdData,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t    state;
    logic [CW-1:0] cnt;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [2:0]    cap_f3;
    logic          cap_we;
    logic [31:0]   rd_q;
    logic          buserr_q;

    logic          access;
    logic          misal;
    logic          start;
    logic          timeout_hit;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_ldata;

    assign access      = MemRead | MemWrite;
    assign misal       = misaligned(Funct3, Addr[1:0]);
    assign start       = (state == S_IDLE) && access && !misal;
    // Last REQ/WAIT cycle allowed before abort; a completion in that same
    // cycle still wins.
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    lsu_align u_align (
        .addr_lo (cap_addr[1:0]),
        .funct3  (cap_f3),
        .wrdata  (cap_wdata),
        .rdata   (mem_rdata),
        .be      (al_be),
        .wdata   (al_wdata),
        .ldata   (al_ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_f3    <= '0;
            cap_we    <= 1'b0;
            rd_q      <= '0;
            buserr_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_q     <= '0;
                    buserr_q <= 1'b0;
                    if (start) begin
                        cap_addr  <= Addr;
                        cap_wdata <= WrData;
                        cap_f3    <= Funct3;
                        cap_we    <= MemWrite;
                        cnt       <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mem_gnt) begin
                        state <= cap_we ? S_DONE : S_WAIT;
                    end else if (timeout_hit) begin
                        state    <= S_DONE;
                        buserr_q <= 1'b1;
                        rd_q     <= '0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid) begin
                        rd_q  <= al_ldata;
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        state    <= S_DONE;
                        buserr_q <= 1'b1;
                        rd_q     <= '0;
                    end
                end
                S_DONE: begin
                    rd_q     <= '0;
                    buserr_q <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall rises in the detect cycle so the instruction holds in MEM while
    // the request is launched from the captured copy.
    assign Stall       = start || (state == S_REQ) || (state == S_WAIT);
    assign MisalignErr = (state == S_IDLE) && access && misal;
    assign BusErr      = (state == S_DONE) && buserr_q;
    assign RdData      = (state == S_DONE) ? rd_q : 32'h0;

    assign mem_req     = (state == S_REQ);
    assign mem_we      = mem_req && cap_we;
    assign mem_addr    = mem_req ? {cap_addr[31:2], 2'b00} : 32'h0;
    assign mem_be      = mem_we ? al_be : 4'h0;
    assign mem_wdata   = mem_we ? al_wdata : 32'h0;

endmodule
